gerador_varredura: RTL and testbench

- Timing and scan generator that sits directly upstream of the 7x5 matrix display stage.
- Produces the fast 3-bit row-scan select (Clock_Linhas, 0..6) and the slow image-alternation select (img_sel).
- Latches the six irrigation status flags once per frame so the display never shows a torn image.
- Driven by the board clock; its outputs connect unmodified to the matrix stage inputs of the same names.

---
 rtl/gerador_varredura_if.sv | 72 +++++++
 rtl/gerador_varredura.sv | 147 ++++++++++++++
 tb/tb_gerador_varredura.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gerador_varredura_if.sv
// Bundle between the scan generator and its neighbours: scan enable, the six
// raw status flags, and the row/image/flag outputs consumed by the 7x5
// matrix display stage.
//
// Handshake: there is no valid/ready pair here. The master owns Enable and
// the *_in flags and may change them at any time. The slave (the scan
// generator) samples them on the rising clock edge. Every slave output is
// registered, so it holds for a whole clock cycle.
interface gerador_varredura_if;

   logic       Enable;
   logic       Critico_in;
   logic       Baixo_in;
   logic       Medio_in;
   logic       Alto_in;
   logic       Aspersao_in;
   logic       Gotejamento_in;

   logic [2:0] Clock_Linhas;
   logic       img_sel;
   logic       Critico;
   logic       Baixo;
   logic       Medio;
   logic       Alto;
   logic       Aspersao;
   logic       Gotejamento;
   logic       Frame_Fim;
   logic       Blank;

   // Sensor/control side: drives enable and the raw flags, observes the scan.
   modport master (
      output Enable,
      output Critico_in,
      output Baixo_in,
      output Medio_in,
      output Alto_in,
      output Aspersao_in,
      output Gotejamento_in,
      input  Clock_Linhas,
      input  img_sel,
      input  Critico,
      input  Baixo,
      input  Medio,
      input  Alto,
      input  Aspersao,
      input  Gotejamento,
      input  Frame_Fim,
      input  Blank
   );

   // Scan generator side.
   modport slave (
      input  Enable,
      input  Critico_in,
      input  Baixo_in,
      input  Medio_in,
      input  Alto_in,
      input  Aspersao_in,
      input  Gotejamento_in,
      output Clock_Linhas,
      output img_sel,
      output Critico,
      output Baixo,
      output Medio,
      output Alto,
      output Aspersao,
      output Gotejamento,
      output Frame_Fim,
      output Blank
   );

endinterface

// File: rtl/gerador_varredura.sv
// Row-scan and image-alternation generator for the 7x5 matrix display.
//
// A prescaler divides the board clock down to one "tick" per row period.
// The row index walks 0..6. One frame is one pass over all seven rows.
// When the row wraps from 6 to 0 (frame end), three things happen on the
// same edge:
//   - the six status flags are latched, so a frame never shows a torn image;
//   - Frame_Fim pulses for one cycle;
//   - the frame counter advances, and it toggles img_sel on its own wrap.
// Enable low freezes every counter and every latched output. Frame_Fim is
// then forced low. Scanning later resumes from the frozen prescaler value,
// so no tick is lost or repeated.
//
// Optional feature, macro ANTIFANTASMA_EN: when it is defined, Blank marks
// the last cycle of each row period. The downstream driver uses that cycle
// as dead-time against ghosting. When it is undefined, Blank is tied to 0.
module gerador_varredura #(
   parameter int unsigned DIV_LINHA      = 1000,
   parameter int unsigned FRAMES_POR_IMG = 50
) (
   input  logic          Clock,
   input  logic          Reset_n,
   gerador_varredura_if.slave bus
);

   // Terminal counts. Only equality compares are used, so the widths need
   // only cover the legal parameter ranges.
   localparam logic [19:0] PRE_MAX   = 20'(DIV_LINHA - 1);
   localparam logic [15:0] FRAME_MAX = 16'(FRAMES_POR_IMG - 1);
   localparam logic [2:0]  ROW_MAX   = 3'd6;

   logic [19:0] pre_cnt;
   logic [19:0] pre_next;
   logic [2:0]  row_cnt;
   logic [15:0] frame_cnt;
   logic        img_sel_q;
   logic        frame_fim_q;
   logic [5:0]  flags_q;
   logic [5:0]  flags_in;
   logic        tick;
   logic        frame_end;

   // One tick per row period, and only while scanning is enabled.
   assign tick      = bus.Enable && (pre_cnt == PRE_MAX);
   assign frame_end = tick && (row_cnt == ROW_MAX);

   // Raw flags packed MSB-first in the same order as the latched outputs.
   assign flags_in = {bus.Critico_in, bus.Baixo_in, bus.Medio_in,
                      bus.Alto_in, bus.Aspersao_in, bus.Gotejamento_in};

   // Next prescaler value: wrap on tick, count while enabled, else hold.
   always_comb begin
      pre_next = pre_cnt;
      if (tick) begin
         pre_next = '0;
      end else if (bus.Enable) begin
         pre_next = pre_cnt + 20'd1;
      end
   end

   // Prescaler register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_next;
      end
   end

   // Row index: advance on every tick, wrap 6 -> 0 so 7 is never produced.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         row_cnt <= '0;
      end else if (tick) begin
         if (row_cnt == ROW_MAX) begin
            row_cnt <= '0;
         end else begin
            row_cnt <= row_cnt + 3'd1;
         end
      end
   end

   // Frame counter and image select: count frames, toggle img_sel on wrap.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt <= '0;
         img_sel_q <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FRAME_MAX) begin
            frame_cnt <= '0;
            img_sel_q <= ~img_sel_q;
         end else begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   // Frame-end pulse. It is low whenever Enable is low, because frame_end
   // requires a tick.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_fim_q <= 1'b0;
      end else begin
         frame_fim_q <= frame_end;
      end
   end

   // Latch the status flags once per frame, on the row wrap only.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         flags_q <= '0;
      end else if (frame_end) begin
         flags_q <= flags_in;
      end
   end

`ifdef ANTIFANTASMA_EN
   logic blank_q;

   // Dead-time flag. It is high for the cycle in which the prescaler sits at
   // its terminal count. Registering from pre_next lines it up with that
   // cycle, so it falls exactly on the row-change edge. With DIV_LINHA = 1
   // the terminal count is 0, so the flag stays high while enabled.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         blank_q <= 1'b0;
      end else begin
         blank_q <= bus.Enable && (pre_next == PRE_MAX);
      end
   end

   assign bus.Blank = blank_q;
`else
   assign bus.Blank = 1'b0;
`endif

   assign bus.Clock_Linhas = row_cnt;
   assign bus.img_sel      = img_sel_q;
   assign bus.Frame_Fim    = frame_fim_q;
   assign bus.Critico      = flags_q[5];
   assign bus.Baixo        = flags_q[4];
   assign bus.Medio        = flags_q[3];
   assign bus.Alto         = flags_q[2];
   assign bus.Aspersao     = flags_q[1];
   assign bus.Gotejamento  = flags_q[0];

endmodule

// File: tb/tb_gerador_varredura.sv
// Self-checking bench for gerador_varredura with DIV_LINHA=4, FRAMES_POR_IMG=2.
// The reference model keeps only the count of enabled clock edges since
// reset. Row, image and pulse expectations are plain arithmetic on that
// count. Latched flags are kept as snapshots in an expected queue.
module tb_gerador_varredura;

   localparam int DIV       = 4;
   localparam int FR        = 2;
   localparam int FRAME_LEN = DIV * 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   gerador_varredura_if intf ();

   gerador_varredura #(
      .DIV_LINHA      (DIV),
      .FRAMES_POR_IMG (FR)
   ) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (intf)
   );

   int         errors = 0;
   int         checks = 0;

   // Reference model state
   int         n;        // enabled edges since reset
   logic       last_en;  // Enable at the most recent edge
   logic [5:0] lat;      // flags sampled at the most recent frame end
   logic [5:0] exp_q[$]; // flag snapshots awaiting their Frame_Fim pulse

   function automatic logic [2:0] exp_row();
      return 3'((n / DIV) % 7);
   endfunction

   function automatic logic exp_img();
      return 1'(((n / FRAME_LEN) / FR) % 2);
   endfunction

   function automatic logic exp_ff();
      return last_en && (n > 0) && ((n % FRAME_LEN) == 0);
   endfunction

   function automatic logic exp_blank();
`ifdef ANTIFANTASMA_EN
      return last_en && ((n % DIV) == DIV - 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [5:0] dut_flags();
      return {intf.Critico, intf.Baixo, intf.Medio,
              intf.Alto, intf.Aspersao, intf.Gotejamento};
   endfunction

   task automatic model_reset();
      n       = 0;
      last_en = 1'b0;
      lat     = '0;
      exp_q.delete();
   endtask

   task automatic drive(input logic en, input logic [5:0] f);
      intf.Enable         = en;
      intf.Critico_in     = f[5];
      intf.Baixo_in       = f[4];
      intf.Medio_in       = f[3];
      intf.Alto_in        = f[2];
      intf.Aspersao_in    = f[1];
      intf.Gotejamento_in = f[0];
   endtask

   // Drive inputs at the falling edge, let one rising edge happen, update the
   // model, then leave the caller 1 time unit past the edge to sample.
   task automatic step(input logic en, input logic [5:0] f);
      @(negedge clk);
      drive(en, f);
      @(posedge clk);
      if (en) begin
         n++;
         if ((n % FRAME_LEN) == 0) begin
            lat = f;
            exp_q.push_back(f);
         end
      end
      last_en = en;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 6'h00);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // Hold reset with enable and all flags high; nothing may move or latch.
      rst_n = 1'b0;
      drive(1'b1, 6'h3F);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (intf.Clock_Linhas !== 3'd0) begin
         errors++;
         $display("FAIL reset_row got=%0d exp=0", intf.Clock_Linhas);
      end
      checks++;
      if (intf.img_sel !== 1'b0) begin
         errors++;
         $display("FAIL reset_img got=%b exp=0", intf.img_sel);
      end
      checks++;
      if (intf.Frame_Fim !== 1'b0) begin
         errors++;
         $display("FAIL reset_ff got=%b exp=0", intf.Frame_Fim);
      end
      checks++;
      if (intf.Blank !== 1'b0) begin
         errors++;
         $display("FAIL reset_blank got=%b exp=0", intf.Blank);
      end
      checks++;
      if (dut_flags() !== 6'h00) begin
         errors++;
         $display("FAIL reset_flags got=%h exp=00", dut_flags());
      end
      apply_reset();
   endtask

   task automatic test_scan();
      logic [5:0] snap;
      apply_reset();
      for (int c = 0; c < 130; c++) begin
         step(1'b1, 6'($urandom));
         checks++;
         if (intf.Clock_Linhas !== exp_row()) begin
            errors++;
            $display("FAIL scan_row n=%0d got=%0d exp=%0d",
                     n, intf.Clock_Linhas, exp_row());
         end
         checks++;
         if (intf.img_sel !== exp_img()) begin
            errors++;
            $display("FAIL scan_img n=%0d got=%b exp=%b", n, intf.img_sel, exp_img());
         end
         checks++;
         if (intf.Frame_Fim !== exp_ff()) begin
            errors++;
            $display("FAIL scan_ff n=%0d got=%b exp=%b", n, intf.Frame_Fim, exp_ff());
         end
         checks++;
         if (intf.Blank !== exp_blank()) begin
            errors++;
            $display("FAIL scan_blank n=%0d got=%b exp=%b", n, intf.Blank, exp_blank());
         end
         if (intf.Frame_Fim === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scan_sb n=%0d unexpected Frame_Fim", n);
            end else begin
               snap = exp_q.pop_front();
               if (dut_flags() !== snap) begin
                  errors++;
                  $display("FAIL scan_sb n=%0d got=%h exp=%h", n, dut_flags(), snap);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scan_sb_left got=%0d exp=0 pending", exp_q.size());
      end
   endtask

   task automatic test_frame_latch();
      logic [5:0] f;
      apply_reset();
      for (int c = 1; c <= 60; c++) begin
         f    = 6'h00;
         f[5] = (c >= 10 && c < 20);
         f[2] = (c >= 30);
         step(1'b1, f);
         checks++;
         if (intf.Critico !== 1'b0) begin
            errors++;
            $display("FAIL latch_critico edge=%0d got=%b exp=0", c, intf.Critico);
         end
         checks++;
         if (intf.Alto !== (c >= 56)) begin
            errors++;
            $display("FAIL latch_alto edge=%0d got=%b exp=%b", c, intf.Alto, c >= 56);
         end
      end
   endtask

   task automatic test_enable_hold();
      apply_reset();
      repeat (6) step(1'b1, 6'h00);
      for (int c = 0; c < 10; c++) begin
         step(1'b0, 6'h3F);
         checks++;
         if (intf.Clock_Linhas !== 3'd1) begin
            errors++;
            $display("FAIL hold_row c=%0d got=%0d exp=1", c, intf.Clock_Linhas);
         end
         checks++;
         if (intf.Frame_Fim !== 1'b0) begin
            errors++;
            $display("FAIL hold_ff c=%0d got=%b exp=0", c, intf.Frame_Fim);
         end
      end
      // The prescaler froze at 2, so the next row change needs two more edges.
      step(1'b1, 6'h00);
      checks++;
      if (intf.Clock_Linhas !== 3'd1) begin
         errors++;
         $display("FAIL resume_row1 got=%0d exp=1", intf.Clock_Linhas);
      end
      step(1'b1, 6'h00);
      checks++;
      if (intf.Clock_Linhas !== 3'd2) begin
         errors++;
         $display("FAIL resume_row2 got=%0d exp=2", intf.Clock_Linhas);
      end
   endtask

   task automatic test_random_enable();
      logic [5:0] snap;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0, 6'($urandom));
         checks++;
         if (intf.Clock_Linhas !== exp_row()) begin
            errors++;
            $display("FAIL renb_row n=%0d got=%0d exp=%0d",
                     n, intf.Clock_Linhas, exp_row());
         end
         checks++;
         if (intf.img_sel !== exp_img()) begin
            errors++;
            $display("FAIL renb_img n=%0d got=%b exp=%b", n, intf.img_sel, exp_img());
         end
         checks++;
         if (intf.Frame_Fim !== exp_ff()) begin
            errors++;
            $display("FAIL renb_ff n=%0d got=%b exp=%b", n, intf.Frame_Fim, exp_ff());
         end
         checks++;
         if (intf.Blank !== exp_blank()) begin
            errors++;
            $display("FAIL renb_blank n=%0d got=%b exp=%b", n, intf.Blank, exp_blank());
         end
         checks++;
         if (dut_flags() !== lat) begin
            errors++;
            $display("FAIL renb_flags n=%0d got=%h exp=%h", n, dut_flags(), lat);
         end
         if (intf.Frame_Fim === 1'b1 && exp_q.size() != 0) begin
            snap = exp_q.pop_front();
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (76) step(1'b1, 6'h3F);
      checks++;
      if (intf.Clock_Linhas !== 3'd5 || intf.img_sel !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre got=row%0d/img%b exp=row5/img1",
                  intf.Clock_Linhas, intf.img_sel);
      end
      // Assert reset in the middle of the clock cycle, well before the next edge.
      #2;
      rst_n = 1'b0;
      drive(1'b0, 6'h3F);
      #1;
      checks++;
      if (intf.Clock_Linhas !== 3'd0 || intf.img_sel !== 1'b0 ||
          intf.Frame_Fim !== 1'b0 || intf.Blank !== 1'b0 || dut_flags() !== 6'h00) begin
         errors++;
         $display("FAIL arst_now got=row%0d/img%b/ff%b/bl%b/flags%h exp=all0",
                  intf.Clock_Linhas, intf.img_sel, intf.Frame_Fim, intf.Blank, dut_flags());
      end
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step(1'b1, 6'h15);
         checks++;
         if (intf.Clock_Linhas !== exp_row() || intf.Frame_Fim !== exp_ff()) begin
            errors++;
            $display("FAIL arst_after n=%0d got=row%0d/ff%b exp=row%0d/ff%b",
                     n, intf.Clock_Linhas, intf.Frame_Fim, exp_row(), exp_ff());
         end
      end
   endtask

   task automatic test_blank();
      int highs;
      int exp_highs;
      highs = 0;
      apply_reset();
      for (int c = 0; c < 40; c++) begin
         step(1'b1, 6'h00);
         if (intf.Blank === 1'b1) highs++;
      end
`ifdef ANTIFANTASMA_EN
      exp_highs = 40 / DIV;
`else
      exp_highs = 0;
`endif
      checks++;
      if (highs != exp_highs) begin
         errors++;
         $display("FAIL blank_count got=%0d exp=%0d", highs, exp_highs);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_scan();
      test_frame_latch();
      test_enable_hold();
      test_random_enable();
      test_async_reset();
      test_blank();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
